// File: rtl/store_byteen_queue_pkg.sv
// Shared definitions for the store byte-enable queue: size codes, lane mask
// helper and a log2 helper for parameter arithmetic.
package store_byteen_queue_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef struct packed {
    logic [7:0] mask;
    logic       misalign;
  } lane_t;

  function automatic int log2_ceil(input int unsigned v);
    int r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // misalign also covers an access wider than the bus (dword on a 32-bit bus)
  function automatic lane_t lane_mask(input logic [1:0] size, input logic [2:0] off,
                                      input int unsigned nb);
    lane_t       r;
    int unsigned bytes;
    logic [15:0] wide;
    bytes      = 32'd1 << size;
    wide       = 16'((32'd1 << bytes) - 32'd1) << off;
    r.mask     = wide[7:0];
    r.misalign = ((32'(off) & (bytes - 32'd1)) != 32'd0) || (bytes > nb);
    return r;
  endfunction

endpackage

// File: rtl/store_byteen_queue_byteen.sv
// Combinational lane placement for one store: byte-enable mask, shifted data
// and the reject flag for misaligned or over-wide accesses.
module byteen_gen
  import store_byteen_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NB     = DATA_W / 8,
  parameter int OFF_W  = log2_ceil(DATA_W / 8)
) (
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] data,
  output logic [NB-1:0]     byteen,
  output logic [DATA_W-1:0] wdata,
  output logic              bad
);

  lane_t lm;
  logic  unused_mask;

  assign lm          = lane_mask(size, 3'(off), NB);
  assign byteen      = lm.mask[NB-1:0];
  assign wdata       = data << {off, 3'b000};
  assign bad         = lm.misalign;
  assign unused_mask = ^lm.mask;

endmodule

// File: rtl/store_byteen_queue.sv
// Store byte-enable generator feeding a DEPTH-entry FIFO that drains to data
// memory, with load-vs-pending-store word hazard detection.
module store_byteen_queue
  import store_byteen_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [1:0]               req_size,
  input  logic [DATA_W-1:0]        req_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W/8-1:0]      mem_byteen,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hazard,
  output logic                     ades,
  output logic [ADDR_W-1:0]        ades_addr,
  output logic [CNT_W-1:0]         count
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = log2_ceil(NB);
  localparam int PTR_W = log2_ceil(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [NB-1:0]     be_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_next;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_next;
  logic              ades_q;
  logic [ADDR_W-1:0] ades_addr_q;

  logic [NB-1:0]     gen_be;
  logic [DATA_W-1:0] gen_wdata;
  logic              gen_bad;
  logic              accept, enq, deq, rej;
  logic              unused_ld_lo;

  byteen_gen #(.DATA_W(DATA_W)) u_byteen_gen (
    .off    (req_addr[OFF_W-1:0]),
    .size   (req_size),
    .data   (req_data),
    .byteen (gen_be),
    .wdata  (gen_wdata),
    .bad    (gen_bad)
  );

  // Both sides use strict valid/ready: a transfer happens on the rising edge
  // where valid && ready; ready never depends combinationally on the other
  // side's valid/ready, and a presented head stays stable until taken.
  assign req_ready = (count_q != CNT_FULL);
  assign mem_valid = (count_q != '0);
  assign accept    = req_valid && req_ready;
  assign enq       = accept && !gen_bad;
  assign rej       = accept && gen_bad;
  assign deq       = mem_valid && mem_ready;

  assign mem_addr   = addr_mem[head_q];
  assign mem_byteen = be_mem[head_q];
  assign mem_wdata  = data_mem[head_q];
  assign ades       = ades_q;
  assign ades_addr  = ades_addr_q;
  assign count      = count_q;

  always_comb begin
    count_next = count_q;
    case ({enq, deq})
      2'b10:   count_next = count_q + CNT_ONE;
      2'b01:   count_next = count_q - CNT_ONE;
      default: count_next = count_q;
    endcase
  end

  // head and tail only coincide when empty or full, so set/clear never collide
  always_comb begin
    valid_next = valid_q;
    if (deq) valid_next[head_q] = 1'b0;
    if (enq) valid_next[tail_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail_q] <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      be_mem[tail_q]   <= gen_be;
      data_mem[tail_q] <= gen_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      ades_q      <= 1'b0;
      ades_addr_q <= '0;
    end else begin
      ades_q  <= rej;
      if (rej) ades_addr_q <= req_addr;
      if (enq) tail_q <= tail_q + PTR_ONE;
      if (deq) head_q <= head_q + PTR_ONE;
      valid_q <= valid_next;
      count_q <= count_next;
    end
  end

  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_mem[i][ADDR_W-1:OFF_W] == ld_addr[ADDR_W-1:OFF_W]))
        ld_hazard = 1'b1;
    end
  end

  assign unused_ld_lo = ^ld_addr[OFF_W-1:0];

endmodule

// File: tb/tb_store_byteen_queue.sv
// Bench for store_byteen_queue: a 32-bit and a 64-bit instance run against a
// queue-based reference model, plus table vectors and hand-written sequences.
module tb_store_byteen_queue;

  localparam int DEPTH = 4;
  typedef logic [103:0] ent_t;  // {addr[31:0], byteen[7:0], wdata[63:0]}

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        v32, mr32, rdy32, mv32, haz32, ades32;
  logic [31:0] a32, ld32, d32, maddr32, aaddr32, wd32;
  logic [1:0]  s32;
  logic [3:0]  be32;
  logic [2:0]  c32;

  logic        v64, mr64, rdy64, mv64, haz64, ades64;
  logic [31:0] a64, ld64, maddr64, aaddr64;
  logic [63:0] d64, wd64;
  logic [1:0]  s64;
  logic [7:0]  be64;
  logic [2:0]  c64;

  store_byteen_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .reset(reset), .req_valid(v32), .req_ready(rdy32), .req_addr(a32),
    .req_size(s32), .req_data(d32), .mem_valid(mv32), .mem_ready(mr32),
    .mem_addr(maddr32), .mem_byteen(be32), .mem_wdata(wd32), .ld_addr(ld32),
    .ld_hazard(haz32), .ades(ades32), .ades_addr(aaddr32), .count(c32));

  store_byteen_queue #(.DATA_W(64), .ADDR_W(32), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .reset(reset), .req_valid(v64), .req_ready(rdy64), .req_addr(a64),
    .req_size(s64), .req_data(d64), .mem_valid(mv64), .mem_ready(mr64),
    .mem_addr(maddr64), .mem_byteen(be64), .mem_wdata(wd64), .ld_addr(ld64),
    .ld_hazard(haz64), .ades(ades64), .ades_addr(aaddr64), .count(c64));

  // ---------------- scoreboard / reference model ----------------
  logic [103:0] exp_q32[$];
  logic [103:0] exp_q64[$];
  logic         m_ades [2];
  logic [31:0]  m_aaddr[2];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int q_size(input int s);
    return (s == 0) ? exp_q32.size() : exp_q64.size();
  endfunction

  function automatic ent_t q_get(input int s, input int i);
    return (s == 0) ? exp_q32[i] : exp_q64[i];
  endfunction

  function automatic logic m_legal(input int unsigned nb, input logic [31:0] a,
                                   input logic [1:0] sz);
    int unsigned bytes, off;
    bytes = 32'd1 << sz;
    off   = a % nb;
    return (bytes <= nb) && ((off % bytes) == 0);
  endfunction

  // Lane placement worked out byte by byte from the store rules.
  function automatic ent_t m_entry(input int unsigned nb, input logic [31:0] a,
                                   input logic [1:0] sz, input logic [63:0] d);
    int unsigned bytes, off;
    logic [7:0]  be;
    logic [63:0] wd;
    bytes = 32'd1 << sz;
    off   = a % nb;
    be    = '0;
    wd    = '0;
    for (int unsigned i = 0; i < nb; i++) begin
      if (i >= off && i < off + bytes) be[i] = 1'b1;
      if (i >= off) wd[8*i +: 8] = d[8*(i-off) +: 8];
    end
    return {a - off, be, wd};
  endfunction

  task automatic model_clear();
    exp_q32.delete();
    exp_q64.delete();
    for (int s = 0; s < 2; s++) begin
      m_ades[s]  = 1'b0;
      m_aaddr[s] = '0;
    end
  endtask

  task automatic model_update();
    logic v, mr, acc, dq, leg;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [63:0] d;
    int unsigned nb;
    int n;
    if (!reset) begin
      model_clear();
      return;
    end
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin v = v32; a = a32; sz = s32; d = {32'h0, d32}; mr = mr32; nb = 4; end
      else        begin v = v64; a = a64; sz = s64; d = d64;          mr = mr64; nb = 8; end
      n   = q_size(s);
      acc = v && (n != DEPTH);
      dq  = (n != 0) && mr;
      leg = m_legal(nb, a, sz);
      m_ades[s] = acc && !leg;
      if (acc && !leg) m_aaddr[s] = a;
      if (dq) begin
        if (s == 0) void'(exp_q32.pop_front()); else void'(exp_q64.pop_front());
      end
      if (acc && leg) begin
        if (s == 0) exp_q32.push_back(m_entry(nb, a, sz, d));
        else        exp_q64.push_back(m_entry(nb, a, sz, d));
      end
    end
  endtask

  task automatic check_dut(input int s);
    logic [7:0]  a_cnt, a_be;
    logic        a_rdy, a_mv, a_haz, a_ades, e_haz;
    logic [31:0] a_maddr, a_aaddr, ld;
    logic [63:0] a_wd;
    ent_t        e;
    int          n;
    string       p;
    int unsigned nb;
    if (s == 0) begin
      p = "d32"; nb = 4; a_cnt = 8'(c32); a_rdy = rdy32; a_mv = mv32; a_haz = haz32;
      a_ades = ades32; a_maddr = maddr32; a_aaddr = aaddr32; a_be = 8'(be32);
      a_wd = 64'(wd32); ld = ld32;
    end else begin
      p = "d64"; nb = 8; a_cnt = 8'(c64); a_rdy = rdy64; a_mv = mv64; a_haz = haz64;
      a_ades = ades64; a_maddr = maddr64; a_aaddr = aaddr64; a_be = be64;
      a_wd = wd64; ld = ld64;
    end
    n = q_size(s);
    chk({p, ".count"}, 64'(a_cnt), 64'(n));
    chk({p, ".req_ready"}, 64'(a_rdy), 64'(n != DEPTH));
    chk({p, ".mem_valid"}, 64'(a_mv), 64'(n != 0));
    if (n != 0) begin
      e = q_get(s, 0);
      chk({p, ".mem_addr"}, 64'(a_maddr), 64'(e[103:72]));
      chk({p, ".mem_byteen"}, 64'(a_be), 64'(e[71:64]));
      chk({p, ".mem_wdata"}, a_wd, e[63:0]);
    end
    e_haz = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = q_get(s, i);
      if ((e[103:72] / nb) == (ld / nb)) e_haz = 1'b1;
    end
    chk({p, ".ld_hazard"}, 64'(a_haz), 64'(e_haz));
    chk({p, ".ades"}, 64'(a_ades), 64'(m_ades[s]));
    chk({p, ".ades_addr"}, 64'(a_aaddr), 64'(m_aaddr[s]));
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic set_req(input int s, input logic v, input logic [31:0] a,
                         input logic [1:0] sz, input logic [63:0] d);
    if (s == 0) begin v32 = v; a32 = a; s32 = sz; d32 = d[31:0]; end
    else        begin v64 = v; a64 = a; s64 = sz; d64 = d; end
  endtask

  task automatic idle_all();
    set_req(0, 1'b0, '0, 2'b00, '0);
    set_req(1, 1'b0, '0, 2'b00, '0);
  endtask

  task automatic drain(input int s);
    int budget;
    budget = 40;
    if (s == 0) mr32 = 1'b1; else mr64 = 1'b1;
    while (q_size(s) != 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_empty", 64'(q_size(s)), 64'd0);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    int          sel;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
    logic        exp_ades;
    logic [7:0]  exp_be;
    logic [63:0] exp_wd;
    logic [31:0] exp_maddr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 32'h10, 2'b10, 64'hA1B2C3D4, 1'b0, 8'h0F, 64'hA1B2C3D4, 32'h10};
    vecs[1] = '{0, 32'h12, 2'b01, 64'hA1B2C3D4, 1'b0, 8'h0C, 64'hC3D40000, 32'h10};
    vecs[2] = '{0, 32'h13, 2'b00, 64'hA1B2C3D4, 1'b0, 8'h08, 64'hD4000000, 32'h10};
    vecs[3] = '{0, 32'h21, 2'b01, 64'hA1B2C3D4, 1'b1, 8'h00, 64'h0, 32'h0};
    vecs[4] = '{0, 32'h22, 2'b10, 64'hA1B2C3D4, 1'b1, 8'h00, 64'h0, 32'h0};
    vecs[5] = '{0, 32'h30, 2'b11, 64'hA1B2C3D4, 1'b1, 8'h00, 64'h0, 32'h0};
    vecs[6] = '{1, 32'h08, 2'b11, 64'h1122334455667788, 1'b0, 8'hFF, 64'h1122334455667788, 32'h08};
    vecs[7] = '{1, 32'h0D, 2'b00, 64'hA1B2C3D4, 1'b0, 8'h20, 64'hB2C3D40000000000, 32'h08};
    vecs[8] = '{1, 32'h0C, 2'b10, 64'hA1B2C3D4, 1'b0, 8'hF0, 64'hA1B2C3D400000000, 32'h08};
    vecs[9] = '{1, 32'h06, 2'b11, 64'h0, 1'b1, 8'h00, 64'h0, 32'h0};

    // clock/reset
    reset = 1'b0;
    idle_all();
    mr32 = 1'b1; mr64 = 1'b1; ld32 = 32'h100; ld64 = 32'h100;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    chk("rst.count", 64'(c32), 64'd0);
    chk("rst.mem_valid", 64'(mv32), 64'd0);
    chk("rst.ades", 64'(ades32), 64'd0);
    chk("rst.ades_addr", 64'(aaddr32), 64'd0);
    chk("rst.ld_hazard", 64'(haz64), 64'd0);
    reset = 1'b1;
    tick();

    // table-driven single stores, drained immediately
    for (int k = 0; k < 10; k++) begin
      set_req(vecs[k].sel, 1'b1, vecs[k].addr, vecs[k].size, vecs[k].data);
      tick();
      idle_all();
      #3;
      if (vecs[k].sel == 0) begin
        chk("vec.ades", 64'(ades32), 64'(vecs[k].exp_ades));
        chk("vec.mem_valid", 64'(mv32), 64'(!vecs[k].exp_ades));
        if (vecs[k].exp_ades) chk("vec.ades_addr", 64'(aaddr32), 64'(vecs[k].addr));
        else begin
          chk("vec.byteen", 64'(be32), 64'(vecs[k].exp_be));
          chk("vec.wdata", 64'(wd32), vecs[k].exp_wd);
          chk("vec.addr", 64'(maddr32), 64'(vecs[k].exp_maddr));
        end
      end else begin
        chk("vec64.ades", 64'(ades64), 64'(vecs[k].exp_ades));
        chk("vec64.mem_valid", 64'(mv64), 64'(!vecs[k].exp_ades));
        if (vecs[k].exp_ades) chk("vec64.ades_addr", 64'(aaddr64), 64'(vecs[k].addr));
        else begin
          chk("vec64.byteen", 64'(be64), 64'(vecs[k].exp_be));
          chk("vec64.wdata", wd64, vecs[k].exp_wd);
          chk("vec64.addr", 64'(maddr64), 64'(vecs[k].exp_maddr));
        end
      end
      tick();
    end

    // ld_hazard on the 64-bit bus
    mr64 = 1'b0;
    set_req(1, 1'b1, 32'h08, 2'b11, 64'hCAFE);
    tick();
    idle_all();
    ld64 = 32'h0A;
    #2 chk("haz.same_word", 64'(haz64), 64'd1);
    ld64 = 32'h10;
    #1 chk("haz.other_word", 64'(haz64), 64'd0);
    drain(1);

    // fill with memory stalled, then release
    mr32 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, 32'h40 + 32'(4*i), 2'b10, 64'(32'h1000 + i));
      tick();
    end
    set_req(0, 1'b1, 32'h50, 2'b10, 64'h5555);
    #3;
    chk("full.count", 64'(c32), 64'd4);
    chk("full.req_ready", 64'(rdy32), 64'd0);
    tick();
    mr32 = 1'b1;
    #1 chk("full.ready_with_mem_ready", 64'(rdy32), 64'd0);
    tick();
    #2;
    chk("full.ready_after_deq", 64'(rdy32), 64'd1);
    chk("full.count_after_deq", 64'(c32), 64'd3);
    chk("full.head_order", 64'(maddr32), 64'h44);
    tick();
    idle_all();
    #2 chk("full.enq_deq_count", 64'(c32), 64'd3);
    drain(0);

    // simultaneous enqueue and dequeue at count=2
    mr32 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(0, 1'b1, 32'h80 + 32'(4*i), 2'b10, 64'(32'hBEEF0 + i));
      tick();
    end
    mr32 = 1'b1;
    set_req(0, 1'b1, 32'h88, 2'b00, 64'h77);
    tick();
    idle_all();
    #2 chk("simul.count", 64'(c32), 64'd2);
    drain(0);

    // ten mixed legal stores across pointer wrap
    for (int i = 0; i < 10; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 2));
      a  = $urandom_range(0, 63) & ~((32'd1 << sz) - 32'd1);
      set_req(0, 1'b1, a, sz, {32'h0, $urandom});
      mr32 = 1'($urandom_range(0, 1));
      ld32 = a;
      tick();
    end
    idle_all();
    drain(0);

    // randomized traffic on both instances
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < 2; s++) begin
        logic [1:0]  sz;
        logic [31:0] a;
        sz = 2'($urandom_range(0, 3));
        a  = $urandom_range(0, 63);
        if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
        set_req(s, 1'($urandom_range(0, 1)), a, sz, {$urandom, $urandom});
      end
      mr32 = 1'($urandom_range(0, 1));
      mr64 = 1'($urandom_range(0, 1));
      ld32 = $urandom_range(0, 63);
      ld64 = $urandom_range(0, 63);
      tick();
    end
    idle_all();
    drain(0);
    drain(1);

    // asynchronous reset with stores pending and an ades pulse in flight
    mr32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1'b1, 32'hC0 + 32'(4*i), 2'b10, 64'(i));
      tick();
    end
    set_req(0, 1'b1, 32'h51, 2'b01, 64'h0);
    tick();
    idle_all();
    reset = 1'b0;
    #1;
    chk("areset.mem_valid", 64'(mv32), 64'd0);
    chk("areset.count", 64'(c32), 64'd0);
    chk("areset.ades", 64'(ades32), 64'd0);
    chk("areset.ld_hazard", 64'(haz32), 64'd0);
    model_clear();
    tick();
    reset = 1'b1;
    set_req(0, 1'b1, 32'h60, 2'b10, 64'h12345678);
    tick();
    idle_all();
    #2;
    chk("post_reset.mem_valid", 64'(mv32), 64'd1);
    chk("post_reset.mem_addr", 64'(maddr32), 64'h60);
    drain(0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_byteen_queue.md
Name: store_byteen_queue

Overview:
- Parametrised successor to the store-side byte-enable generator in the MEM stage.
- Takes a store request (address, raw register data, access size) and checks alignment. It computes the per-byte enable mask and the lane-shifted write data, and handles 32- or 64-bit data buses.
- Legal stores go into a DEPTH-entry FIFO that drains to data memory over a valid/ready handshake. The block also flags loads whose word matches a pending store, so the pipeline can stall.

Parameters:
DATA_W, 32, data bus width in bits; legal values 32 or 64; NB = DATA_W/8 byte lanes
ADDR_W, 32, byte address width
DEPTH, 4, FIFO entries; power of two, 2..16
CNT_W, $clog2(DEPTH)+1, occupancy counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  store request present
req_ready  out  1  block can accept a request this cycle
req_addr  in  ADDR_W  byte address
req_size  in  2  00 byte, 01 half, 10 word, 11 dword
req_data  in  DATA_W  unshifted store data, LSB-aligned
mem_valid  out  1  head entry valid toward memory
mem_ready  in  1  memory accepts head entry
mem_addr  out  ADDR_W  head address, low log2(NB) bits forced to 0
mem_byteen  out  NB  head byte-enable mask
mem_wdata  out  DATA_W  head lane-shifted data
ld_addr  in  ADDR_W  address of the load currently in MEM
ld_hazard  out  1  a valid entry holds the same bus word as ld_addr
ades  out  1  one-cycle pulse: misaligned or illegal-size store rejected
ades_addr  out  ADDR_W  offending address, held until the next ades
count  out  CNT_W  current occupancy

Behaviour:
- Reset (reset=0, asynchronous):
  - head pointer, tail pointer and count go to 0; all entry valid bits clear.
  - mem_valid=0, ades=0, ades_addr=0, ld_hazard=0.
  - Memory contents of the entries are don't-care.
- Byte offset and size:
  - off = req_addr[log2(NB)-1:0]; size bytes = 1 << req_size.
  - Misaligned when off is not a multiple of size bytes.
  - req_size=11 is illegal when DATA_W=32.
- Mask and data:
  - mask = ((1<<size bytes)-1) << off.
  - data = req_data << (8*off); bits shifted out are discarded.
  - Example, DATA_W=32, half at off=2: mask 4'b1100, data << 16.
- Handshake:
  - req_ready = (count != DEPTH); purely from registered state, with no combinational path from mem_ready.
  - A request is accepted when req_valid && req_ready.
  - A legal accepted request writes mask, data and word-aligned address at the tail, increments the tail and sets the entry valid bit.
  - An illegal accepted request is consumed but not enqueued. ades=1 on the next cycle and ades_addr latches req_addr; count is unchanged.
- Drain:
  - mem_valid = (count != 0); mem_addr, mem_byteen and mem_wdata come straight from the head entry registers.
  - On mem_valid && mem_ready the head advances and its valid bit clears.
  - mem_* outputs must hold stable while mem_valid && !mem_ready.
- Latency: a legal store accepted in cycle N is presented on mem_* no earlier than cycle N+1 (no bypass).
- Simultaneous events:
  - Enqueue and dequeue in the same cycle leave count unchanged; legal only when count is not DEPTH.
  - When full, req_ready=0 even if mem_ready=1 that cycle.
  - An illegal request with a simultaneous dequeue gives count−1 plus the ades pulse.
- Pointers:
  - log2(DEPTH) bits wide; they wrap modulo DEPTH naturally.
  - count is the sole full/empty source.
- ld_hazard (combinational): OR over all valid entries of (entry addr[ADDR_W-1:log2(NB)] == ld_addr[ADDR_W-1:log2(NB)]). Entries dequeuing this cycle still count.
- Reset mid-operation drops all pending stores without asserting ades.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - a function lane_mask(size, off, NB) returning the mask and misalign flag;
  - the log2 helper.
- One natural sub-module, byteen_gen: combinational mask/shift/misalign for one request, parametrised on DATA_W.
- The top level holds the FIFO, pointers, ades register and hazard compare.

Test Plan:
- DATA_W=32, stores to 0x10 (word), 0x12 (half), 0x13 (byte), data 0xA1B2C3D4, mem_ready=1 -> mem_byteen 1111/1100/1000; mem_wdata 0xA1B2C3D4 / 0xC3D40000 / 0xD4000000; mem_addr 0x10 for all three.
- Misaligned: half at 0x21, word at 0x22, dword with DATA_W=32 -> ades pulses 1 cycle each; ades_addr 0x21, 0x22, then the dword address; count stays 0; mem_valid stays 0.
- Fill with mem_ready=0, DEPTH=4: four legal stores -> count=4, req_ready=0. A fifth req_valid is held off; raise mem_ready -> entries drain in order, req_ready returns the cycle after the first dequeue.
- Simultaneous: count=2, legal enqueue plus dequeue in the same cycle -> count stays 2; FIFO order preserved across pointer wrap over 10 mixed stores.
- DATA_W=64: dword at 0x08 -> byteen 0xFF; byte at 0x0D -> byteen 0x20, data << 40. ld_addr=0x0A while the 0x08 entry is pending -> ld_hazard=1; ld_addr=0x10 -> 0.
- Assert reset low with 3 entries pending and mem_ready=0 -> mem_valid, count and ades go to 0 immediately; after release a new store is accepted normally.
